// File: rtl/alu_pkg.sv
// Shared op/state encodings and a small overflow helper for the sequential ALU.
// The optional iterative multiplier is enabled by defining ALU_MUL_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_MUL  = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } alu_state_e;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU slice: B inversion, shared adder, logic ops, SLT and
// carry/overflow. MUL is handled by alu_seq; here code 011 yields zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic        [WIDTH-1:0] b_eff;
  logic        [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] diff_s;
  logic                    ovf_raw;
  logic                    slt;

  always_comb begin
    b_eff   = f[2] ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, f[2]};
    diff_s  = sum[WIDTH-1:0];
    ovf_raw = add_ovf(a[WIDTH-1], b_eff[WIDTH-1], diff_s[WIDTH-1]);
    // Sign of the true difference is the wrapped sign corrected by overflow.
    slt     = diff_s[WIDTH-1] ^ ovf_raw;

    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_e'(f))
      ALU_AND, ALU_ANDN: y = a & b_eff;
      ALU_OR, ALU_ORN:   y = a | b_eff;
      ALU_ADD, ALU_SUB: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ovf_raw;
      end
      ALU_SLT:           y = {{(WIDTH-1){1'b0}}, slt};
      default:           y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered-output ALU with optional shift-add multiplier.
// Define ALU_MUL_EN to build the iterative MUL path; otherwise op 011 returns 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] core_y;
  logic             core_carry;
  logic             core_ovf;

  logic             accept;
  logic             mul_accept;
  logic             mul_last;
  logic [WIDTH-1:0] mul_sum;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .f        (f),
    .y        (core_y),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mul_accept = accept && (alu_op_e'(f) == ALU_MUL);
  assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last   = (state_q == ST_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy       = (state_q == ST_MUL);

  // One multiplier bit per cycle: add the shifted multiplicand when the
  // current low bit of the multiplier is set.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (mul_accept) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == ST_MUL) begin
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign mul_accept = 1'b0;
  assign mul_last   = 1'b0;
  assign mul_sum    = '0;
  assign busy       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_accept) state_d = ST_MUL;
      ST_MUL:  if (mul_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers only change on a fresh result; otherwise they hold,
  // which keeps them stable while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    y_d         = y_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    if (accept && !mul_accept) begin
      y_d         = core_y;
      zero_d      = (core_y == '0);
      carry_d     = core_carry;
      overflow_d  = core_ovf;
      out_valid_d = 1'b1;
    end else if (mul_last) begin
      y_d         = mul_sum;
      zero_d      = (mul_sum == '0);
      carry_d     = 1'b0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32) with an arithmetic reference model and
// in-order scoreboard. Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t exp_q[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf);
    exp_t   e;
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    e.y = 32'd0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (tf)
      3'b000: e.y = ta & tb;
      3'b001: e.y = ta | tb;
      3'b100: e.y = ta & ~tb;
      3'b101: e.y = ta | ~tb;
      3'b010: begin
        p   = {32'd0, ta} + {32'd0, tb};
        e.y = p[31:0];
        e.c = p[32];
        r   = sa + sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        e.y = ta - tb;
        e.c = (ta >= tb);
        r   = sa - sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: e.y = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_MUL_EN
        p   = {32'd0, ta} * {32'd0, tb};
        e.y = p[31:0];
`else
        e.y = 32'd0;
`endif
      end
    endcase
    e.z = (e.y == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard: inputs change only just after posedge, so the negedge view
  // is exactly what the next edge will see.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          check("sb_y", {32'd0, y}, {32'd0, exp_q[0].y});
          check("sb_flags", {61'd0, zero, carry, overflow},
                {61'd0, exp_q[0].z, exp_q[0].c, exp_q[0].v});
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model(a, b, f));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    f        = tf;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accepted", {63'd0, ok}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] sa_v[8];
  logic [31:0] sb_v[8];
  logic [2:0]  sf_v[8];
  int          lat;
  int          seen;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    f         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y", {32'd0, y}, 64'd0);
    check("rst_flags", {60'd0, zero, carry, overflow, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // ADD overflow into the sign bit
    send(32'h7FFF_FFFF, 32'h1, 3'b010);
    @(negedge clk);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_y", {32'd0, y}, 64'h8000_0000);
    check("add_flags_zcv", {61'd0, zero, carry, overflow}, 64'b001);
    step();

    send(32'd5, 32'd5, 3'b110);
    @(negedge clk);
    check("sub_y", {32'd0, y}, 64'd0);
    check("sub_flags_zcv", {61'd0, zero, carry, overflow}, 64'b110);
    step();

    send(32'h8000_0000, 32'd1, 3'b111);
    @(negedge clk);
    check("slt_y", {32'd0, y}, 64'd1);
    check("slt_flags_zcv", {61'd0, zero, carry, overflow}, 64'b000);
    step();

    // Consumer stall: output must hold and input side must block
    out_ready = 1'b0;
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_y", {32'd0, y}, 64'hF000_F000);
      check("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'b10);
    end
    step();
    out_ready = 1'b1;
    send(32'h1234_0000, 32'h0000_5678, 3'b001);
    @(negedge clk);
    check("b2b_or_y", {32'd0, y}, 64'h1234_5678);
    step();

`ifdef ALU_MUL_EN
    send(32'd123456, 32'd1000, 3'b011);
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0) check("mul_busy_blocked", {62'd0, busy, in_ready}, 64'b10);
      if (out_valid) break;
      lat++;
    end
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_y", {32'd0, y}, 64'h075B_CA00);
    check("mul_done_busy", {63'd0, busy}, 64'd0);
    step();

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("mul_wrap_y", {32'd0, y}, 64'd1);
    step();

    send(32'h0001_0000, 32'h0001_0000, 3'b011);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("mul_zero_zcv", {29'd0, y, zero, carry, overflow}, 64'b100);
    step();

    // Abort a multiply with reset on its tenth cycle
    send(32'd7, 32'd9, 3'b011);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
`else
    send(32'd123456, 32'd1000, 3'b011);
    @(negedge clk);
    check("mul_off_y", {32'd0, y}, 64'd0);
    check("mul_off_zcvb", {60'd0, out_valid, zero, carry, overflow}, 64'b1100);
    check("mul_off_busy", {63'd0, busy}, 64'd0);
    step();

    // Reset while a result is stalled at the output
    out_ready = 1'b0;
    send(32'd1, 32'd2, 3'b010);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
`endif
    @(negedge clk);
    check("abort_state", {61'd0, out_valid, busy, in_ready}, 64'b001);
    check("abort_y", {32'd0, y}, 64'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    step();

    // Back-to-back stream of single-cycle ops
    sa_v = '{32'h0000_000F, 32'h0000_000F, 32'hFFFF_FFFF, 32'd3,
             32'h8000_0000, 32'd5, 32'hFFFF_0000, 32'h0000_1234};
    sb_v = '{32'h0000_00F0, 32'h0000_00F0, 32'd1, 32'd5,
             32'd1, 32'hFFFF_FFFD, 32'hF0F0_F0F0, 32'hFFFF_00FF};
    sf_v = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b110, 3'b111, 3'b100, 3'b101};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a        = sa_v[i];
      b        = sb_v[i];
      f        = sf_v[i];
      @(negedge clk);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (i > 0) check("stream_out_valid", {63'd0, out_valid}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", {63'd0, out_valid}, 64'd1);
    check("stream_last_y", {32'd0, y}, 64'h0000_FF34);
    step();
    @(negedge clk);
    check("stream_drained", {63'd0, out_valid}, 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
